vec_result_serializer: RTL
==========================

# vec_result_serializer

Drains one `VECTOR`-lane result vector, such as the `out` array of `vector_mac`, onto a single-element valid/ready stream, lane 0 first. It is the consumer end of the vector MAC datapath: it captures a full vector in one cycle and then emits one `I_WIDTH` element per accepted beat. This lets a narrow downstream path (writeback, FIFO, bus master) take results without a `VECTOR`-wide port. It sustains back-to-back vectors with no bubble between the last element of one vector and the first element of the next.

## Interface
- `I_WIDTH`, default 32 (instantiated with the `` `I_WIDTH `` macro), element width in bits.
- `VECTOR`, default 4 (instantiated with the `` `VECTOR `` macro), number of lanes; must be ≥ 1.
- `IW`, derived as max(1, $clog2(VECTOR)), lane index width; not overridable.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `vec_valid`  in  1  upstream presents a full vector on `vec_in`.
- `vec_ready`  out  1  block accepts `vec_in` this cycle.
- `vec_in`  in  [I_WIDTH-1:0] x [VECTOR-1:0] (unpacked array)  result lanes; index i is lane i.
- `elem_valid`  out  1  `elem_data` holds a valid element.
- `elem_ready`  in  1  downstream accepts the element this cycle.
- `elem_data`  out  I_WIDTH  current lane value.
- `elem_idx`  out  IW  lane index of `elem_data`.
- `elem_last`  out  1  current element is lane VECTOR-1.
- `busy`  out  1  a vector is held and not yet fully drained (equals `elem_valid`).
- `vec_done_cnt`  out  16  count of vectors fully drained; wraps.

## Operation
- **Handshakes.**
  - Vector handshake: `vec_valid && vec_ready` at a rising edge.
  - Element handshake: `elem_valid && elem_ready` at a rising edge.
- **State machine.** Two states, IDLE and DRAIN. The block holds a `VECTOR` x `I_WIDTH` capture buffer and an IW-bit lane counter `idx`.
- **IDLE.**
  - `vec_ready`=1 and `elem_valid`=0.
  - On a vector handshake: capture all lanes into the buffer, set `idx`=0, go to DRAIN.
- **DRAIN.**
  - `elem_valid`=1.
  - `elem_data`=buffer[idx], `elem_idx`=idx, `elem_last`=(idx==VECTOR-1).
- **DRAIN, non-last element handshake.** `idx` increments; stay in DRAIN.
- **DRAIN, last element handshake.**
  - `vec_done_cnt` increments (0xFFFF wraps to 0x0000).
  - If `vec_valid` is also high in the same cycle: capture the new vector, set `idx`=0, stay in DRAIN.
  - Otherwise go to IDLE.
- **`vec_ready` in DRAIN.** Equals `elem_ready && elem_last`. This is a combinational path from `elem_ready`; no other combinational input-to-output paths exist.
- **Stalls.** While `elem_valid && !elem_ready`, `elem_data`, `elem_idx` and `elem_last` hold stable.
- **`vec_in` is sampled only on a vector handshake.** Changes on `vec_in` at any other time have no effect.
- **`VECTOR`=1.** Every element is last; `idx` stays 0.
- **`elem_last` is gated.** It is 0 whenever `elem_valid` is 0.
- **Reset (`rst_n` low), asynchronous.**
  - State goes to IDLE; `idx`=0, buffer=0, `vec_done_cnt`=0.
  - `elem_valid`=0, `elem_data`=0, `elem_idx`=0, `elem_last`=0, `busy`=0.
  - `vec_ready`=0 while `rst_n` is low, then 1 from the first cycle after release.
- **Reset mid-drain.** Remaining lanes are discarded and no partial count is recorded.

## Timing
- **Latency.** A vector accepted at edge k has lane 0 valid on `elem_data` from just after edge k; the first element handshake can occur at edge k+1.
- **Throughput.** With `elem_ready` held at 1, the block delivers one element per cycle and one vector every `VECTOR` cycles. The next vector handshake coincides with the last element handshake, so there is no idle cycle.
- **`vec_done_cnt` update.** It updates at the edge of the last element handshake and is visible the following cycle.
- **Reset release.** De-assertion is expected synchronous to `clk` (synchronized externally); the block takes no action on the release edge other than leaving reset.

## Test plan
- **Reset values.**
  - Stimulus: assert `rst_n`=0 mid-DRAIN (lane 2 of 4 pending).
  - Required: `elem_valid`/`elem_data`/`elem_idx`/`elem_last`/`busy`/`vec_done_cnt`/`vec_ready` all 0 immediately; after release, `vec_ready`=1 and no further elements appear.
- **Single vector, free-running sink.**
  - Stimulus: `VECTOR`=4, `vec_in`={0x3F800000, 0x40000000, 0x40400000, 0x40800000}, `elem_ready`=1.
  - Required: 4 consecutive beats, `elem_idx` 0..3, data in lane order, `elem_last` only on beat 4, `vec_done_cnt`=1.
- **Back-to-back vectors.**
  - Stimulus: `vec_valid` held high with two distinct vectors.
  - Required: 8 elements in 8 consecutive cycles; the second vector handshake coincides with lane 3 of the first.
- **Backpressure.**
  - Stimulus: `elem_ready` toggles 1,0,0,1,0,1,1; `vec_in` changes while draining.
  - Required: outputs stable during stalls, captured values delivered unchanged, `vec_ready`=0 until the last handshake.
- **Counter wrap.**
  - Stimulus: drain 65537 vectors.
  - Required: `vec_done_cnt` reads 0xFFFF after 65535 vectors, 0x0000 after 65536, and 0x0001 after 65537.
- **`VECTOR`=1 build.**
  - Stimulus: stream 3 vectors with `elem_ready`=1.
  - Required: `elem_last`=1 and `elem_idx`=0 on every beat, one element per cycle.

Source files
------------

// File: rtl/vec_result_serializer_if.sv
// vec_result_serializer_if: vector-in / element-out handshake bundle for vec_result_serializer
`ifndef I_WIDTH
`define I_WIDTH 32
`endif
`ifndef VECTOR
`define VECTOR 4
`endif
interface vec_result_serializer_if #(
  parameter int I_WIDTH = `I_WIDTH,
  parameter int VECTOR  = `VECTOR
);
  localparam int IW = VECTOR > 1 ? $clog2(VECTOR) : 1;
  logic               vec_valid;
  logic               vec_ready;
  logic [I_WIDTH-1:0] vec_in [VECTOR];
  logic               elem_valid;
  logic               elem_ready;
  logic [I_WIDTH-1:0] elem_data;
  logic [IW-1:0]      elem_idx;
  logic               elem_last;
  modport master (
    output vec_valid, vec_in, elem_ready,
    input  vec_ready, elem_valid, elem_data, elem_idx, elem_last
  );
  modport slave (
    input  vec_valid, vec_in, elem_ready,
    output vec_ready, elem_valid, elem_data, elem_idx, elem_last
  );
endinterface

// File: rtl/vec_result_serializer.sv
// vec_result_serializer: captures a VECTOR-lane result and streams it out one element per beat, lane 0 first
module vec_result_serializer #(
  parameter int I_WIDTH = `I_WIDTH,
  parameter int VECTOR  = `VECTOR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vec_result_serializer_if.slave  s,
  output logic                    busy,
  output logic [15:0]             vec_done_cnt
);
  localparam int IW = VECTOR > 1 ? $clog2(VECTOR) : 1;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t             state, next_state;
  logic [I_WIDTH-1:0] lanes [VECTOR];
  logic [IW-1:0]      idx;
  logic               last_lane, vec_hs, elem_hs;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // a vector handshake in DRAIN only happens alongside the last element, so it always lands in DRAIN
  always_comb begin
    vec_hs     = s.vec_valid && s.vec_ready;
    elem_hs    = s.elem_valid && s.elem_ready;
    next_state = vec_hs ? DRAIN : (elem_hs && s.elem_last) ? IDLE : state;
  end
  always_comb begin
    last_lane    = idx == IW'(VECTOR - 1);
    s.elem_valid = state == DRAIN;
    s.elem_last  = s.elem_valid && last_lane;
    s.elem_data  = s.elem_valid ? lanes[idx] : '0;
    s.elem_idx   = s.elem_valid ? idx : '0;
    s.vec_ready  = rst_n && (!s.elem_valid || (s.elem_ready && s.elem_last));
    busy         = s.elem_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lanes        <= '{default: '0};
      idx          <= '0;
      vec_done_cnt <= '0;
    end else begin
      if (vec_hs) lanes <= s.vec_in;
      idx <= (vec_hs || (elem_hs && last_lane)) ? '0 : elem_hs ? idx + 1'b1 : idx;
      if (elem_hs && last_lane) vec_done_cnt <= vec_done_cnt + 16'd1;
    end
endmodule
